// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and FSM-state definitions for the ALU slice.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_ADC  = 3'b001,
    ALU_SUB  = 3'b010,
    ALU_SBC  = 3'b011,
    ALU_AND  = 3'b100,
    ALU_OR   = 3'b101,
    ALU_XOR  = 3'b110,
    ALU_PASS = 3'b111
  } alu_op_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_EXEC  = 2'd2
  } alu_state_t;

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle between the shifter-side controller and alu_core.
interface alu_if #(parameter int WIDTH = 8);

  logic             start;
  logic [2:0]       operation;
  logic [WIDTH-1:0] lhs_in;
  logic             lhs_carry_in;
  logic [WIDTH-1:0] rhs_in;
  logic             flags_load;
  logic [3:0]       flags_in;
  logic             result_oe;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] bus_out;
  logic [3:0]       flags;
  logic             carry_flag;
  logic             busy;
  logic             done;

  modport master (
    output start, operation, lhs_in, lhs_carry_in, rhs_in,
           flags_load, flags_in, result_oe,
    input  result, bus_out, flags, carry_flag, busy, done
  );

  modport slave (
    input  start, operation, lhs_in, lhs_carry_in, rhs_in,
           flags_load, flags_in, result_oe,
    output result, bus_out, flags, carry_flag, busy, done
  );

endinterface

// File: rtl/alu_adder.sv
// Combinational WIDTH-bit adder with optional b inversion; reports carry-out
// and two's-complement overflow against the effective addend.
module alu_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             invert_b,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   total;

  // Sum is one bit wider than the operands so the top bit is the carry.
  always_comb begin
    b_eff    = invert_b ? ~b : b;
    total    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, carry_in};
    sum      = total[WIDTH-1:0];
    carry    = total[WIDTH];
    overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end

endmodule

// File: rtl/alu_core.sv
// ALU stage after the shifter: latches operands, executes one op, registers
// result and N/V/C/Z. The carry flag loops back to the shifter carry input.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting; accepts start or flags_load (flags_load wins)
// ST_LATCH | operands captured, settle cycle before execute
// ST_EXEC  | compute; result/flags/done registered on leaving
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic  clk,
  input logic  reset,
  alu_if.slave bus
);

  alu_state_t       state_q, state_d;
  alu_op_t          op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             lhs_carry_q;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q;
  logic             done_q;

  logic             capture, exec_en, flags_restore, busy;

  logic             add_cin, add_inv, add_carry, add_ovf;
  logic [WIDTH-1:0] add_sum;
  logic [WIDTH-1:0] alu_r;
  logic [3:0]       alu_f;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; a flag restore in IDLE suppresses a simultaneous start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.start && !bus.flags_load) state_d = ST_LATCH;
      ST_LATCH: state_d = ST_EXEC;
      ST_EXEC:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM-derived strobes.
  always_comb begin
    capture       = (state_q == ST_IDLE) && bus.start && !bus.flags_load;
    flags_restore = (state_q == ST_IDLE) && bus.flags_load;
    exec_en       = (state_q == ST_EXEC);
    busy          = (state_q != ST_IDLE);
  end

  // Operand latch, so later input changes cannot disturb the in-flight op.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q        <= ALU_ADD;
      a_q         <= '0;
      b_q         <= '0;
      lhs_carry_q <= 1'b0;
    end else if (capture) begin
      op_q        <= alu_op_t'(bus.operation);
      a_q         <= bus.lhs_in;
      b_q         <= bus.rhs_in;
      lhs_carry_q <= bus.lhs_carry_in;
    end
  end

  // Adder control: subtraction uses the inverted addend, carry-in from flag C.
  always_comb begin
    add_inv = 1'b0;
    add_cin = 1'b0;
    case (op_q)
      ALU_ADC: add_cin = flags_q[FLAG_C];
      ALU_SUB: begin add_inv = 1'b1; add_cin = 1'b1; end
      ALU_SBC: begin add_inv = 1'b1; add_cin = flags_q[FLAG_C]; end
      default: ;
    endcase
  end

  alu_adder #(.WIDTH(WIDTH)) u_adder (
    .a        (a_q),
    .b        (b_q),
    .carry_in (add_cin),
    .invert_b (add_inv),
    .sum      (add_sum),
    .carry    (add_carry),
    .overflow (add_ovf)
  );

  // Result and flag selection for the EXEC cycle.
  always_comb begin
    alu_r         = add_sum;
    alu_f         = '0;
    alu_f[FLAG_C] = add_carry;
    alu_f[FLAG_V] = add_ovf;
    case (op_q)
      ALU_AND:  begin alu_r = a_q & b_q; alu_f[FLAG_C] = 1'b0; alu_f[FLAG_V] = 1'b0; end
      ALU_OR:   begin alu_r = a_q | b_q; alu_f[FLAG_C] = 1'b0; alu_f[FLAG_V] = 1'b0; end
      ALU_XOR:  begin alu_r = a_q ^ b_q; alu_f[FLAG_C] = 1'b0; alu_f[FLAG_V] = 1'b0; end
      ALU_PASS: begin alu_r = a_q; alu_f[FLAG_C] = lhs_carry_q; alu_f[FLAG_V] = 1'b0; end
      default:  ;
    endcase
    alu_f[FLAG_N] = alu_r[WIDTH-1];
    alu_f[FLAG_Z] = (alu_r == '0);
  end

  // Result/flag registers; the carry only moves on EXEC or a restore.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= exec_en;
      if (exec_en) begin
        result_q <= alu_r;
        flags_q  <= alu_f;
      end else if (flags_restore) begin
        flags_q  <= bus.flags_in;
      end
    end
  end

  assign bus.result     = result_q;
  assign bus.bus_out    = bus.result_oe ? result_q : '0;
  assign bus.flags      = flags_q;
  assign bus.carry_flag = flags_q[FLAG_C];
  assign bus.busy       = busy;
  assign bus.done       = done_q;

endmodule
